arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
- Parametrised N-to-1 arbitrated selector with valid/ready handshake on every input and a registered output stage.
- Shares one downstream resource among N requesters, for example a shared memory port fed by instruction fetch and data access in the multi-cycle core.
- Adds to plain 2-to-1 selection: arbitration, back-pressure, a one-beat output buffer, and a selectable arbitration mode.

Parameters:
- WIDTH, 32, payload width in bits of each input and of the output.
- N, 4, number of input channels; legal range 1..16.
- ARB_MODE, ARB_RR, arbitration mode from the shared package: ARB_RR = round-robin, ARB_FIXED = fixed priority with the lowest index winning.
- SELW, (N>1 ? $clog2(N) : 1), derived width of the grant index; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  N  per-channel request valid.
- in_data  in  N x WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept; at most one bit high per cycle.
- out_valid  out  1  output register holds a beat.
- out_data  out  WIDTH  registered payload.
- out_sel  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  downstream accept.

Behaviour:
- **Interface.** One clock domain (clk). Reset rst is synchronous and active-high.
- **Reset values.**
  - out_valid=0, out_data=0, out_sel=0.
  - in_ready is all-zero during rst.
  - Round-robin pointer last_grant=N-1, so channel 0 has top priority first.
- **Reset mid-operation.** A held beat is discarded; no in_ready is asserted in the reset cycle.
- **State.** Two-state output FSM, EMPTY (out_valid=0) and FULL (out_valid=1).
- **Load condition.** load_ok = EMPTY, or FULL with out_ready=1 (pass-through refill, no bubble).
- **Grant.** When load_ok and any in_valid is high, exactly one channel g is granted and in_ready[g]=1. All other in_ready bits are 0.
  - in_ready is combinational from in_valid, out_valid, out_ready and the pointer.
  - in_ready never depends on in_data.
- **Transfer.** Channel g transfers in that cycle. On the next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1.
- **Latency and throughput.** Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 beat per cycle.
- **Hold.** FULL with out_ready=0: out_data and out_sel are held stable and in_ready is all-zero.
- **Drain.** FULL, out_ready=1, no in_valid: goes to EMPTY. out_data keeps its last value, which is don't-care while out_valid=0.
- **ARB_RR.**
  - Search order is last_grant+1, last_grant+2, … modulo N, wrapping from N-1 to 0.
  - last_grant updates to g only on an accepted transfer.
  - No starvation: any continuously-valid channel is granted within N accepts.
- **ARB_FIXED.** Lowest-index valid channel wins. last_grant is unused and held at reset value.
- **N=1.** in_ready[0]=load_ok, out_sel is always 0, and mode is irrelevant.
- **Upstream rule.** Upstream must hold in_valid and in_data stable until accepted; the block does not check this.
- **Withdrawn request.** Dropping in_valid before accept is tolerated; that channel simply is not granted.
- **Simultaneous events.** FULL + out_ready=1 + new request: the output beat leaves and the new beat loads on the same edge, so out_valid stays 1.
- **Assertions (simulation only).**
  - $onehot0(in_ready).
  - out_data and out_sel stable while out_valid && !out_ready.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
  - localparam ARB_MAX_N=16.
  - function sel_width(n).
- Sub-module rr_picker #(N):
  - Purely combinational.
  - Inputs: req[N], last[SELW], mode.
  - Outputs: onehot gnt[N] and encoded idx[SELW].
  - Implementation: double-width rotate-and-mask priority search.
- arb_mux instantiates one rr_picker and adds the output register and FSM.

Test Plan:
- Reset priority: WIDTH=32, N=4, RR; assert rst 2 cycles, release; in_valid=4'b1111, data i=32'hA0+i, out_ready=1 -> in_ready=0001 first cycle. Outputs A0,A1,A2,A3,A0 with out_sel 0,1,2,3,0 on consecutive cycles, out_valid stays 1.
- Back-pressure: hold out_ready=0 for 5 cycles with a beat FULL (data 32'hDEAD_BEEF, sel 2) -> out_data/out_sel unchanged, in_ready=0000 throughout. Release -> next beat appears the following cycle with no bubble.
- Fixed mode: ARB_FIXED, in_valid=4'b1010 constant, out_ready=1 -> channel 1 granted every cycle. Channel 3 never granted while channel 1 is valid.
- Wrap and sparse: RR, last_grant=3, in_valid=4'b0100 -> grant channel 2. Then in_valid=4'b0101 -> grant channel 0 (search 3→0), then channel 2.
- Reset mid-transfer: out_valid=1 with beat pending, out_ready=0; pulse rst 1 cycle -> out_valid=0, out_data=0, in_ready=0 that cycle. Next grant goes to channel 0.
- N=1 and N=3 builds: N=1 passes 100 random beats in order with random out_ready and out_sel=0. N=3 RR wraps 2→0, and SELW=2 is checked.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated N-to-1 selector.
package arb_pkg;

    // Arbitration policy: rotating priority or lowest-index-wins.
    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

    // Largest supported channel count.
    localparam int ARB_MAX_N = 16;

    // Width of a channel index for n channels (at least one bit).
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_mux_rr_picker.sv
// Combinational picker: chooses one requester, either round-robin after
// 'last' or fixed priority from index 0, by rotating a doubled request
// vector so the search always starts at bit 0.
module rr_picker
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] last,
    input  arb_mode_e       mode,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic           found;
    int             start;
    int             pos;

    // Rotate the doubled request so the first candidate sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req};
        start = 0;
        if (mode == ARB_RR) begin
            start = int'(last) + 1;
            if (start >= N) start = 0;
        end
        rot   = dbl >> start;
        found = 1'b0;
        pos   = 0;
        // The upper half only repeats the lower half, so it never changes the winner.
        for (int k = 0; k < 2 * N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = (start + k) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            gnt[i] = found && (pos == i);
        end
        idx = found ? SELW'(pos) : '0;
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrated selector with valid/ready on every input and a
// one-beat registered output stage. A full output refills on the same
// edge it drains, so throughput is one beat per cycle.
module arb_mux
    import arb_pkg::*;
#(
    parameter int        WIDTH    = 32,
    parameter int        N        = 4,
    parameter arb_mode_e ARB_MODE = ARB_RR,
    localparam int       SELW     = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e            state;
    logic [SELW-1:0]   last_grant;
    logic [N-1:0]      gnt;
    logic [SELW-1:0]   idx;
    logic              load_ok;
    logic              accept;
    logic [WIDTH-1:0]  gdata;

    rr_picker #(.N(N)) u_picker (
        .req  (in_valid),
        .last (last_grant),
        .mode (ARB_MODE),
        .gnt  (gnt),
        .idx  (idx)
    );

    assign out_valid = (state == FULL);
    assign load_ok   = !out_valid || out_ready;
    // A single channel is always offered a slot when one exists; with
    // several channels only the picked requester sees ready.
    assign in_ready  = (load_ok && !rst) ? ((N == 1) ? {N{1'b1}} : gnt) : '0;
    assign accept    = |(in_ready & in_valid);

    // One-hot payload mux driven by the grant vector.
    always_comb begin
        gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gdata = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output FSM: load on accept, drain to EMPTY when the beat leaves with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SELW'(N - 1);
        end else if (accept) begin
            state    <= FULL;
            out_data <= gdata;
            out_sel  <= idx;
            if (ARB_MODE == ARB_RR) last_grant <= idx;
        end else if (out_valid && out_ready) begin
            state <= EMPTY;
        end
    end

`ifndef SYNTHESIS
    a_onehot_ready : assert property (@(posedge clk) $onehot0(in_ready));
    a_hold_stable  : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_sel)));
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: four builds (N=4 RR, N=4 fixed, N=1, N=3 RR) share one
// stimulus stream and are each compared every cycle with a scan-based model.
module tb_arb_mux;
    import arb_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   vin;
    logic [31:0]  dw [4];
    logic [127:0] din;
    logic         ordy;

    always #5 clk = ~clk;
    assign din = {dw[3], dw[2], dw[1], dw[0]};

    logic [3:0]  rdy_a, rdy_b;
    logic [0:0]  rdy_c;
    logic [2:0]  rdy_d;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic [31:0] od_a, od_b, od_c, od_d;
    logic [1:0]  os_a, os_b, os_d;
    logic [0:0]  os_c;

    arb_mux #(.WIDTH(32), .N(4), .ARB_MODE(ARB_RR)) dut_a (
        .clk(clk), .rst(rst), .in_valid(vin), .in_data(din), .in_ready(rdy_a),
        .out_valid(ov_a), .out_data(od_a), .out_sel(os_a), .out_ready(ordy));
    arb_mux #(.WIDTH(32), .N(4), .ARB_MODE(ARB_FIXED)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vin), .in_data(din), .in_ready(rdy_b),
        .out_valid(ov_b), .out_data(od_b), .out_sel(os_b), .out_ready(ordy));
    arb_mux #(.WIDTH(32), .N(1), .ARB_MODE(ARB_RR)) dut_c (
        .clk(clk), .rst(rst), .in_valid(vin[0:0]), .in_data(din[31:0]), .in_ready(rdy_c),
        .out_valid(ov_c), .out_data(od_c), .out_sel(os_c), .out_ready(ordy));
    arb_mux #(.WIDTH(32), .N(3), .ARB_MODE(ARB_RR)) dut_d (
        .clk(clk), .rst(rst), .in_valid(vin[2:0]), .in_data(din[95:0]), .in_ready(rdy_d),
        .out_valid(ov_d), .out_data(od_d), .out_sel(os_d), .out_ready(ordy));

    logic [3:0]  rdy_o [4];
    logic        ov_o  [4];
    logic [31:0] od_o  [4];
    logic [1:0]  os_o  [4];

    always_comb begin
        rdy_o[0] = rdy_a;          rdy_o[1] = rdy_b;
        rdy_o[2] = {3'b000, rdy_c}; rdy_o[3] = {1'b0, rdy_d};
        ov_o[0] = ov_a; ov_o[1] = ov_b; ov_o[2] = ov_c; ov_o[3] = ov_d;
        od_o[0] = od_a; od_o[1] = od_b; od_o[2] = od_c; od_o[3] = od_d;
        os_o[0] = os_a; os_o[1] = os_b; os_o[2] = {1'b0, os_c}; os_o[3] = os_d;
    end

    // Reference model state per build.
    int          nn [4] = '{4, 4, 1, 3};
    bit          fx [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit          mfull [4];
    logic [31:0] mdata [4];
    int          msel  [4];
    int          mlast [4];
    int          seen_rdy [4];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner by the stated rule: scan from the start point, wrapping at n.
    function automatic int pick(input logic [3:0] mask, input int n, input int last, input bit fixed);
        int start;
        int c;
        start = fixed ? 0 : (last + 1) % n;
        for (int k = 0; k < n; k++) begin
            c = (start + k) % n;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 4; d++) begin
            mfull[d] = 1'b0; mdata[d] = '0; msel[d] = 0; mlast[d] = nn[d] - 1;
        end
    endfunction

    // One clock cycle: drive, check ready, check outputs, advance model. Entered and left at posedge+1.
    task automatic step(input bit r, input logic [3:0] vm, input bit ready);
        int g [4];
        int er;
        bit ld;
        rst = r; vin = vm; ordy = ready;
        #1;
        for (int d = 0; d < 4; d++) begin
            ld = !mfull[d] || ready;
            g[d] = -1;
            er = 0;
            if (!r && ld) begin
                if (nn[d] == 1) begin
                    er = 1;
                    if (vm[0]) g[d] = 0;
                end else begin
                    g[d] = pick(vm, nn[d], mlast[d], fx[d]);
                    if (g[d] >= 0) er = 1 << g[d];
                end
            end
            seen_rdy[d] = int'(rdy_o[d]);
            chk($sformatf("in_ready[dut%0d]", d), 64'(rdy_o[d]), 64'(er));
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("out_valid[dut%0d]", d), 64'(ov_o[d]), 64'(mfull[d]));
            chk($sformatf("out_data[dut%0d]", d), 64'(od_o[d]), 64'(mdata[d]));
            chk($sformatf("out_sel[dut%0d]", d), 64'(os_o[d]), 64'(msel[d]));
        end
        @(posedge clk);
        for (int d = 0; d < 4; d++) begin
            if (r) begin
                mfull[d] = 1'b0; mdata[d] = '0; msel[d] = 0; mlast[d] = nn[d] - 1;
            end else if (g[d] >= 0) begin
                mfull[d] = 1'b1; mdata[d] = dw[g[d]]; msel[d] = g[d];
                if (!fx[d]) mlast[d] = g[d];
            end else if (mfull[d] && ready) begin
                mfull[d] = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; vin = '0; ordy = 1'b0;
        for (int i = 0; i < 4; i++) dw[i] = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset priority and round-robin order from reset.
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) dw[i] = 32'hA0 + i;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            if (i == 0) chk("rp_first_ready", 64'(seen_rdy[0]), 64'h1);
            chk("rp_data", 64'(od_a), 64'(32'hA0 + (i % 4)));
            chk("rp_sel", 64'(os_a), 64'(i % 4));
            chk("rp_valid", 64'(ov_a), 64'h1);
        end

        // Back-pressure on a full beat, then release with no bubble.
        dw[2] = 32'hDEAD_BEEF;
        step(1'b0, 4'b0100, 1'b1);
        chk("bp_load_data", 64'(od_a), 64'(32'hDEAD_BEEF));
        chk("bp_load_sel", 64'(os_a), 64'h2);
        dw[3] = 32'h3333_0003;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1011, 1'b0);
            chk("bp_hold_ready", 64'(seen_rdy[0]), 64'h0);
            chk("bp_hold_data", 64'(od_a), 64'(32'hDEAD_BEEF));
            chk("bp_hold_sel", 64'(os_a), 64'h2);
        end
        step(1'b0, 4'b1011, 1'b1);
        chk("bp_release_ready", 64'(seen_rdy[0]), 64'h8);
        chk("bp_release_data", 64'(od_a), 64'(32'h3333_0003));
        chk("bp_release_valid", 64'(ov_a), 64'h1);

        // Fixed priority: channel 1 beats channel 3 every cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b1010, 1'b1);
            chk("fx_ready", 64'(seen_rdy[1]), 64'h2);
            chk("fx_sel", 64'(os_b), 64'h1);
        end

        // Wrap and sparse requests on the round-robin build (last grant is 3 here).
        step(1'b0, 4'b0100, 1'b1);
        chk("wrap_sel_a", 64'(os_a), 64'h2);
        step(1'b0, 4'b0101, 1'b1);
        chk("wrap_sel_b", 64'(os_a), 64'h0);
        step(1'b0, 4'b0101, 1'b1);
        chk("wrap_sel_c", 64'(os_a), 64'h2);

        // Reset while a beat is held.
        step(1'b0, 4'b0001, 1'b1);
        step(1'b0, 4'b1111, 1'b0);
        chk("rm_held", 64'(ov_a), 64'h1);
        step(1'b1, 4'b1111, 1'b0);
        chk("rm_ready", 64'(seen_rdy[0]), 64'h0);
        chk("rm_valid", 64'(ov_a), 64'h0);
        chk("rm_data", 64'(od_a), 64'h0);
        step(1'b0, 4'b1111, 1'b1);
        chk("rm_next_ready", 64'(seen_rdy[0]), 64'h1);
        chk("rm_next_sel", 64'(os_a), 64'h0);
        chk("n3_sel0", 64'(os_d), 64'h0);

        // Three-channel round robin wraps 2 -> 0.
        step(1'b0, 4'b0111, 1'b1);
        chk("n3_sel1", 64'(os_d), 64'h1);
        step(1'b0, 4'b0111, 1'b1);
        chk("n3_sel2", 64'(os_d), 64'h2);
        step(1'b0, 4'b0111, 1'b1);
        chk("n3_wrap", 64'(os_d), 64'h0);

        // Randomized traffic with random back-pressure and rare resets.
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 4; c++) dw[c] = $urandom;
            step(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
